// File: rtl/apb_regs_wait.sv
// rtl/apb_regs_wait.sv - APB4 completer register bank with configurable wait states
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous reset, active low
//   base_addr_i  byte address of register 0 (word-aligned)
//   apb_req_i    APB request (paddr, pprot, psel, penable, pwrite, pwdata, pstrb)
//   apb_resp_o   APB response (pready, prdata, pslverr)
//   reg_load_i   per-register hardware load enable
//   reg_d_i      hardware load data, one word per register
//   reg_q_o      current register contents

package apb_regs_wait_pkg;

   typedef struct packed {
      logic [31:0] paddr;
      logic [2:0]  pprot;
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
   } apb_req_t;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_resp_t;

endpackage

module apb_regs_wait #(
   parameter int unsigned                        NoRegs     = 8,
   parameter int unsigned                        AddrWidth  = 32,
   parameter int unsigned                        DataWidth  = 32,
   parameter int unsigned                        WaitCycles = 1,
   parameter logic [NoRegs-1:0]                  ReadOnly   = '0,
   parameter logic [NoRegs-1:0][DataWidth-1:0]   RegRstVal  = '0,
   parameter type                                apb_req_t  = apb_regs_wait_pkg::apb_req_t,
   parameter type                                apb_resp_t = apb_regs_wait_pkg::apb_resp_t
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [AddrWidth-1:0]               base_addr_i,
   input  apb_req_t                           apb_req_i,
   output apb_resp_t                          apb_resp_o,
   input  logic [NoRegs-1:0]                  reg_load_i,
   input  logic [NoRegs-1:0][DataWidth-1:0]   reg_d_i,
   output logic [NoRegs-1:0][DataWidth-1:0]   reg_q_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned IdxShift  = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = (NoRegs > 1) ? $clog2(NoRegs) : 1;
   localparam int unsigned CntWidth  = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_e;

   state_e                             state_q, state_d;
   logic [CntWidth-1:0]                cnt_q, cnt_d, cnt_inc;
   logic [NoRegs-1:0][DataWidth-1:0]   regs_q, regs_d;

   logic [AddrWidth-1:0]   paddr;
   logic [DataWidth-1:0]   pwdata;
   logic [StrbWidth-1:0]   pstrb;
   logic                   psel, penable, pwrite;
   logic                   unused_pprot;

   assign paddr        = apb_req_i.paddr;
   assign pwdata       = apb_req_i.pwdata;
   assign pstrb        = apb_req_i.pstrb;
   assign psel         = apb_req_i.psel;
   assign penable      = apb_req_i.penable;
   assign pwrite       = apb_req_i.pwrite;
   assign unused_pprot = ^apb_req_i.pprot;

   // Address decode. A base above paddr makes the subtraction wrap, which the
   // explicit >= compare rejects; low offset bits are dropped so unaligned
   // addresses alias onto their word.
   logic [AddrWidth-1:0]   offset, idx_full;
   logic [IdxWidth-1:0]    idx;
   logic                   in_range;

   assign offset   = paddr - base_addr_i;
   assign idx_full = offset >> IdxShift;
   assign idx      = idx_full[IdxWidth-1:0];
   assign in_range = (paddr >= base_addr_i) && (idx_full < AddrWidth'(NoRegs));

   // ST_DONE always means cnt_q == WaitCycles, so the completion cycle is simply
   // ST_DONE with an ACCESS phase on the bus.
   logic done, wr_en, rd_ok, err;

   assign done  = (state_q == ST_DONE) && psel && penable;
   assign wr_en = done && pwrite && in_range && !ReadOnly[idx];
   assign rd_ok = done && !pwrite && in_range;
   assign err   = done && (!in_range || (pwrite && ReadOnly[idx]));

   assign cnt_inc = cnt_q + CntWidth'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               cnt_d   = '0;
               state_d = (WaitCycles == 0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               // Aborted transfer: drop it silently.
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (!penable) begin
               // A new SETUP restarts the wait count.
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CntWidth'(WaitCycles)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (psel && !penable) begin
               cnt_d   = '0;
               state_d = (WaitCycles == 0) ? ST_DONE : ST_WAIT;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Hardware load is applied first so that strobed APB bytes override it and
   // unstrobed bytes keep the load data on a same-edge collision.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NoRegs; i++) begin
         if (reg_load_i[i]) begin
            regs_d[i] = reg_d_i[i];
         end
         if (wr_en && (idx == IdxWidth'(i))) begin
            for (int b = 0; b < StrbWidth; b++) begin
               if (pstrb[b]) begin
                  regs_d[i][b*8 +: 8] = pwdata[b*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q <= RegRstVal;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign reg_q_o = regs_q;

   always_comb begin
      apb_resp_o         = '0;
      apb_resp_o.pready  = done;
      apb_resp_o.prdata  = rd_ok ? regs_q[idx] : '0;
      apb_resp_o.pslverr = err;
   end

endmodule

// File: tb/tb_apb_regs_wait.sv
// tb/tb_apb_regs_wait.sv - directed self-checking bench for apb_regs_wait

module tb_apb_regs_wait;

   import apb_regs_wait_pkg::*;

   localparam logic [7:0]        RO  = 8'b0000_0100;
   localparam logic [7:0][31:0]  RST = {32'h0, 32'h0, 32'h0, 32'h0,
                                        32'hCAFE_0003, 32'h0, 32'h0, 32'h0};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       base = 32'h0;
   logic              use_z = 1'b0;
   apb_req_t          req, req_z, req_w;
   apb_resp_t         resp, resp_z, resp_w;
   logic [7:0]        reg_load = '0;
   logic [7:0][31:0]  reg_d = '0;
   logic [7:0][31:0]  reg_q_z, reg_q_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign req_z = use_z ? req : '0;
   assign req_w = use_z ? '0 : req;
   assign resp  = use_z ? resp_z : resp_w;

   apb_regs_wait #(
      .NoRegs(8), .AddrWidth(32), .DataWidth(32), .WaitCycles(0),
      .ReadOnly(RO), .RegRstVal(RST)
   ) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .base_addr_i(base),
      .apb_req_i(req_z), .apb_resp_o(resp_z),
      .reg_load_i(reg_load), .reg_d_i(reg_d), .reg_q_o(reg_q_z)
   );

   apb_regs_wait #(
      .NoRegs(8), .AddrWidth(32), .DataWidth(32), .WaitCycles(2),
      .ReadOnly(RO), .RegRstVal(RST)
   ) dut_w (
      .clk_i(clk), .rst_ni(rst_n), .base_addr_i(base),
      .apb_req_i(req_w), .apb_resp_o(resp_w),
      .reg_load_i(reg_load), .reg_d_i(reg_d), .reg_q_o(reg_q_w)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives SETUP then ACCESS and returns at the negedge of the completing
   // cycle with the bus still driven, so the next call runs back-to-back.
   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int waits);
      @(posedge clk); #1;
      req.paddr   = addr;
      req.pwrite  = wr;
      req.pwdata  = wdata;
      req.pstrb   = strb;
      req.pprot   = 3'b010;
      req.psel    = 1'b1;
      req.penable = 1'b0;
      @(posedge clk); #1;
      req.penable = 1'b1;
      @(negedge clk);
      waits = 0;
      while (resp.pready !== 1'b1 && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      chk("pready_timeout", resp.pready, 1'b1);
      rdata = resp.prdata;
      err   = resp.pslverr;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req.psel    = 1'b0;
      req.penable = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0]  rd;
   logic         er;
   int           wt;
   logic [31:0]  model [8];
   int           ix;
   logic [31:0]  dv;

   initial begin
      req = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp", resp_w, '0);
      chk("rst_reg3", reg_q_w[3], 32'hCAFE_0003);
      chk("rst_reg1", reg_q_w[1], 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Zero-wait read
      use_z = 1'b1;
      apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, wt);
      chk("z_waits", wt, 0);
      chk("z_rdata", rd, 32'hCAFE_0003);
      chk("z_err", er, 1'b0);
      idle();
      use_z = 1'b0;

      // Strobed write with two wait states, then back-to-back readback
      apb(1'b1, 32'h04, 32'h1122_3344, 4'b0101, rd, er, wt);
      chk("w_waits", wt, 2);
      chk("w_err", er, 1'b0);
      apb(1'b0, 32'h04, 32'h0, 4'h0, rd, er, wt);
      chk("w_rdata", rd, 32'h0022_0044);
      chk("w_rwaits", wt, 2);
      idle();
      chk("w_regq1", reg_q_w[1], 32'h0022_0044);

      // Read-only protection and hardware load
      apb(1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
      chk("ro_err", er, 1'b1);
      idle();
      chk("ro_regq2", reg_q_w[2], 32'h0);
      @(posedge clk); #1;
      reg_load = 8'b0000_0100;
      reg_d[2] = 32'h5;
      @(posedge clk); #1;
      reg_load = '0;
      @(negedge clk);
      chk("ro_load", reg_q_w[2], 32'h5);
      apb(1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt);
      chk("ro_rdata", rd, 32'h5);
      chk("ro_rerr", er, 1'b0);

      // Out of range with base 0x1000
      idle();
      base = 32'h1000;
      apb(1'b0, 32'h1020, 32'h0, 4'h0, rd, er, wt);
      chk("oor_hi_err", er, 1'b1);
      chk("oor_hi_rdata", rd, 32'h0);
      apb(1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, wt);
      chk("oor_lo_err", er, 1'b1);
      chk("oor_lo_rdata", rd, 32'h0);
      apb(1'b0, 32'h100C, 32'h0, 4'h0, rd, er, wt);
      chk("base_rdata", rd, 32'hCAFE_0003);
      apb(1'b1, 32'h101F, 32'hDEAD_BEEF, 4'hF, rd, er, wt);
      chk("alias_err", er, 1'b0);
      idle();
      chk("alias_regq7", reg_q_w[7], 32'hDEAD_BEEF);

      // Collision of APB write and hardware load on reg 5
      reg_load = 8'b0010_0000;
      reg_d[5] = 32'h1234_5678;
      apb(1'b1, 32'h1014, 32'hAAAA_AAAA, 4'b0011, rd, er, wt);
      @(posedge clk); #1;
      req.psel    = 1'b0;
      req.penable = 1'b0;
      reg_load    = '0;
      @(negedge clk);
      chk("coll_regq5", reg_q_w[5], 32'h1234_AAAA);

      // psel dropped during WAIT
      @(posedge clk); #1;
      req.paddr = 32'h1000; req.pwrite = 1'b1; req.pwdata = 32'h5555_5555;
      req.pstrb = 4'hF; req.psel = 1'b1; req.penable = 1'b0;
      @(posedge clk); #1;
      req.penable = 1'b1;
      @(negedge clk);
      chk("abort_wait_pready", resp_w.pready, 1'b0);
      @(posedge clk); #1;
      req.psel    = 1'b0;
      req.penable = 1'b0;
      @(negedge clk);
      chk("abort_resp", resp_w, '0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_regq0", reg_q_w[0], 32'h0);
      apb(1'b0, 32'h1018, 32'h0, 4'h0, rd, er, wt);
      chk("abort_next_waits", wt, 2);
      chk("abort_next_err", er, 1'b0);

      // Back-to-back writes to random registers against a reference model
      model[0] = 32'h0;           model[1] = 32'h0022_0044;
      model[2] = 32'h5;           model[3] = 32'hCAFE_0003;
      model[4] = 32'h0;           model[5] = 32'h1234_AAAA;
      model[6] = 32'h0;           model[7] = 32'hDEAD_BEEF;
      for (int k = 0; k < 6; k++) begin
         ix = $urandom_range(0, 7);
         if (ix == 2) ix = 4;
         dv = $urandom;
         apb(1'b1, 32'h1000 + 32'(ix * 4), dv, 4'hF, rd, er, wt);
         chk("rnd_werr", er, 1'b0);
         model[ix] = dv;
      end
      for (int k = 0; k < 8; k++) begin
         apb(1'b0, 32'h1000 + 32'(k * 4), 32'h0, 4'h0, rd, er, wt);
         chk($sformatf("rnd_rd%0d", k), rd, model[k]);
      end

      // Reset pulsed during the completing ACCESS cycle
      apb(1'b1, 32'h1004, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
      chk("rst_mid_pready_before", resp_w.pready, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_resp", resp_w, '0);
      chk("rst_mid_reg1", reg_q_w[1], 32'h0);
      chk("rst_mid_reg3", reg_q_w[3], 32'hCAFE_0003);
      chk("rst_mid_reg7", reg_q_w[7], 32'h0);
      req.psel    = 1'b0;
      req.penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_after_reg1", reg_q_w[1], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
